// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared widths, grant encoding and FSM states for mem_port_arbiter
package mem_arb_pkg;
  localparam int ADDR_W = 22;
  localparam int DATA_W = 32;
  localparam int NUM_PORTS = 3;
  localparam logic [1:0] GRANT_NONE = 2'b11;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: lowest-index winner, with age-saturated requesters taking precedence
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] aged,
  output logic                 valid,
  output logic [1:0]           idx
);
  logic [NUM_PORTS-1:0] pool;
  always_comb begin
    pool = |(req & aged) ? (req & aged) : req;
    valid = |req;
    idx = pool[0] ? 2'd0 : pool[1] ? 2'd1 : 2'd2;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: 3-port fixed-priority memory arbiter with timeout; MEM_ARB_AGING_EN adds anti-starvation aging
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int AGE_LIMIT = 15,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_PORTS-1:0]          m_req,
  input  logic [NUM_PORTS-1:0]          m_rw,
  input  logic [NUM_PORTS*ADDR_W-1:0]   m_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   m_wdata,
  output logic [NUM_PORTS-1:0]          m_ack,
  output logic [NUM_PORTS-1:0]          m_err,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          mc_req,
  output logic                          mc_rw,
  output logic [ADDR_W-1:0]             mc_addr,
  output logic [DATA_W-1:0]             mc_wdata,
  input  logic                          mc_ack,
  input  logic [DATA_W-1:0]             mc_rdata,
  output logic [1:0]                    grant_id,
  output logic                          busy
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  arb_state_t state;
  logic [TW-1:0] tcnt;
  logic [NUM_PORTS-1:0] aged;
  logic win_valid;
  logic [1:0] win_idx;
  logic timeout;
  logic rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  assign busy = state == ARB_BUSY;
  assign mc_req = busy;
  assign m_rdata = mc_rdata;
  assign timeout = busy && tcnt == TW'(TIMEOUT_CYC) && !mc_ack;
  mem_arb_pick u_pick (
    .req  (m_req),
    .aged (aged),
    .valid(win_valid),
    .idx  (win_idx)
  );
  // Payload follows the granted slice in BUSY and holds its last value in IDLE.
  always_comb begin
    mc_rw = rw_q;
    mc_addr = addr_q;
    mc_wdata = wdata_q;
    m_ack = '0;
    m_err = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (busy && grant_id == 2'(i)) begin
        mc_rw = m_rw[i];
        mc_addr = m_addr[i*ADDR_W +: ADDR_W];
        mc_wdata = m_wdata[i*DATA_W +: DATA_W];
        m_ack[i] = mc_ack;
        m_err[i] = timeout;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ARB_IDLE;
      grant_id <= GRANT_NONE;
      tcnt <= '0;
      rw_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else if (state == ARB_IDLE) begin
      if (win_valid) begin
        state <= ARB_BUSY;
        grant_id <= win_idx;
        tcnt <= '0;
      end
    end else begin
      rw_q <= mc_rw;
      addr_q <= mc_addr;
      wdata_q <= mc_wdata;
      if (mc_ack || timeout) begin
        state <= ARB_IDLE;
        grant_id <= GRANT_NONE;
      end
      if (!mc_ack && tcnt != TW'(TIMEOUT_CYC)) tcnt <= tcnt + 1'b1;
    end
  end
`ifdef MEM_ARB_AGING_EN
  localparam int AW = $clog2(AGE_LIMIT + 1);
  logic [AW-1:0] age [NUM_PORTS];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PORTS; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++)
        age[i] <= (!m_req[i] || grant_id == 2'(i) || (!busy && win_valid && win_idx == 2'(i))) ? '0 :
                  (age[i] == AW'(AGE_LIMIT)) ? age[i] : age[i] + 1'b1;
    end
  end
  always_comb begin
    aged = '0;
    for (int i = 0; i < NUM_PORTS; i++) aged[i] = age[i] == AW'(AGE_LIMIT);
  end
`else
  assign aged = '0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector-table and directed-sequence checks of mem_port_arbiter (honours MEM_ARB_AGING_EN)
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [2:0] m_req = '0;
  logic [2:0] m_rw = 3'b101;
  logic [65:0] m_addr;
  logic [95:0] m_wdata;
  logic [2:0] m_ack, m_err;
  logic [31:0] m_rdata;
  logic mc_req, mc_rw;
  logic [21:0] mc_addr;
  logic [31:0] mc_wdata;
  logic mc_ack = 1'b0;
  logic [31:0] mc_rdata = '0;
  logic [1:0] grant_id;
  logic busy;
  int total = 0;
  int bad = 0;
  logic [21:0] ad [3];
  logic [31:0] wd [3];

  mem_port_arbiter #(.NUM_PORTS(3), .AGE_LIMIT(3), .TIMEOUT_CYC(255)) dut (
    .clk(clk), .reset_n(reset_n), .m_req(m_req), .m_rw(m_rw), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
    .mc_req(mc_req), .mc_rw(mc_rw), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
    .mc_ack(mc_ack), .mc_rdata(mc_rdata), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  req;
    logic        ack;
    logic [31:0] rd;
    logic [1:0]  gid;
    logic        bsy;
    logic        rw;
    logic [21:0] addr;
    logic [2:0]  mack;
  } vec_t;
  vec_t v [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_timeout(input bit ack_last);
    int first_err = -1;
    int pulses = 0;
    step();
    m_req = 3'b100;
    mc_ack = 1'b0;
    for (int n = 1; n <= 256; n++) begin
      step();
      if (n == 256) mc_ack = ack_last;
      #1;
      if (m_err != 3'b000) begin
        pulses++;
        if (first_err < 0) first_err = n;
      end
      if (n == 256) begin
        chk("to_busy_last", busy, 1);
        chk("to_ack_last", m_ack, ack_last ? 3'b100 : 3'b000);
      end
    end
    chk("to_err_pulses", pulses, ack_last ? 0 : 1);
    chk("to_err_cycle", first_err, ack_last ? -1 : 256);
    step();
    m_req = 3'b000;
    mc_ack = 1'b0;
    #1;
    chk("to_after_mc_req", mc_req, 0);
    chk("to_after_busy", busy, 0);
    chk("to_after_gid", grant_id, 3);
    chk("to_after_err", m_err, 0);
  endtask

  initial begin
    int g_exp [6];
    int ng;
    ad[0] = 22'h000111; ad[1] = 22'h00ABC; ad[2] = 22'h2F00F;
    wd[0] = 32'hA0A0_A0A0; wd[1] = 32'hB1B1_B1B1; wd[2] = 32'hC2C2_C2C2;
    m_addr = {ad[2], ad[1], ad[0]};
    m_wdata = {wd[2], wd[1], wd[0]};
    v[0]  = '{3'b111, 1'b0, 32'h0,         2'd3, 1'b0, 1'b0, 22'h0,     3'b000};
    v[1]  = '{3'b111, 1'b0, 32'h0,         2'd0, 1'b1, 1'b1, 22'h000111, 3'b000};
    v[2]  = '{3'b111, 1'b1, 32'hDEAD_0000, 2'd0, 1'b1, 1'b1, 22'h000111, 3'b001};
    v[3]  = '{3'b110, 1'b0, 32'h0,         2'd3, 1'b0, 1'b1, 22'h000111, 3'b000};
    v[4]  = '{3'b110, 1'b0, 32'h0,         2'd1, 1'b1, 1'b0, 22'h00ABC, 3'b000};
    v[5]  = '{3'b110, 1'b1, 32'h0000_BEEF, 2'd1, 1'b1, 1'b0, 22'h00ABC, 3'b010};
    v[6]  = '{3'b100, 1'b0, 32'h0,         2'd3, 1'b0, 1'b0, 22'h00ABC, 3'b000};
    v[7]  = '{3'b100, 1'b0, 32'h0,         2'd2, 1'b1, 1'b1, 22'h2F00F, 3'b000};
    v[8]  = '{3'b100, 1'b1, 32'h5555_0002, 2'd2, 1'b1, 1'b1, 22'h2F00F, 3'b100};
    v[9]  = '{3'b000, 1'b0, 32'h0,         2'd3, 1'b0, 1'b1, 22'h2F00F, 3'b000};
    v[10] = '{3'b010, 1'b0, 32'h0,         2'd3, 1'b0, 1'b1, 22'h2F00F, 3'b000};
    v[11] = '{3'b010, 1'b0, 32'h0,         2'd1, 1'b1, 1'b0, 22'h00ABC, 3'b000};
    v[12] = '{3'b010, 1'b1, 32'h1234_5678, 2'd1, 1'b1, 1'b0, 22'h00ABC, 3'b010};
    v[13] = '{3'b000, 1'b0, 32'h0,         2'd3, 1'b0, 1'b0, 22'h00ABC, 3'b000};

    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("rst_gid", grant_id, 3);
      chk("rst_mc_req", mc_req, 0);
      chk("rst_busy", busy, 0);
    end

    for (int k = 0; k < 14; k++) begin
      step();
      m_req = v[k].req;
      mc_ack = v[k].ack;
      mc_rdata = v[k].rd;
      #1;
      chk($sformatf("v%0d_gid", k), grant_id, v[k].gid);
      chk($sformatf("v%0d_busy", k), busy, v[k].bsy);
      chk($sformatf("v%0d_mc_req", k), mc_req, v[k].bsy);
      chk($sformatf("v%0d_rw", k), mc_rw, v[k].rw);
      chk($sformatf("v%0d_addr", k), mc_addr, v[k].addr);
      chk($sformatf("v%0d_m_ack", k), m_ack, v[k].mack);
      chk($sformatf("v%0d_m_err", k), m_err, 0);
      if (v[k].bsy) chk($sformatf("v%0d_wdata", k), mc_wdata, wd[v[k].gid]);
      if (v[k].mack != 3'b000) chk($sformatf("v%0d_rdata", k), m_rdata, v[k].rd);
    end
    mc_ack = 1'b0;

    run_timeout(1'b0);
    run_timeout(1'b1);

`ifdef MEM_ARB_AGING_EN
    ng = 3;
    g_exp = '{0, 0, 2, 0, 0, 0};
`else
    ng = 6;
    g_exp = '{0, 0, 0, 0, 0, 0};
`endif
    step();
    m_req = 3'b101;
    for (int g = 0; g < ng; g++) begin
      chk($sformatf("age_idle%0d", g), busy, 0);
      step();
      chk($sformatf("age_grant%0d", g), grant_id, 2'(g_exp[g]));
      mc_ack = 1'b1;
      step();
      mc_ack = 1'b0;
    end
    m_req = 3'b000;
    step();

    m_req = 3'b001;
    step();
    chk("mid_busy", busy, 1);
    mc_ack = 1'b1;
    #1;
    chk("mid_ack_pre", m_ack, 3'b001);
    reset_n = 1'b0;
    #1;
    chk("mid_mc_req", mc_req, 0);
    chk("mid_busy_rst", busy, 0);
    chk("mid_m_ack", m_ack, 0);
    chk("mid_m_err", m_err, 0);
    chk("mid_gid", grant_id, 3);
    mc_ack = 1'b0;
    m_req = 3'b000;
    #1 reset_n = 1'b1;
    step();
    chk("post_rst_gid", grant_id, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
